autotest_crc32_uut: RTL and testbench

Example unit-under-test stage for the autotest core. It consumes the stimulus vector and hold/control strobe produced by the autotest FSM and computes a bit-serial CRC-32 (IEEE 802.3, reflected) over the stimulus bytes. It returns two results with level done flags: the CRC and the number of cycles the run took. The FSM latches both results and writes them back to SD.

---
 rtl/autotest_crc32_uut.sv | 115 +++++++++++
 tb/tb_autotest_crc32_uut.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/autotest_crc32_uut.sv
// autotest_crc32_uut
// Bit-serial CRC-32 (IEEE 802.3, reflected) over a DATA_BYTES stimulus vector,
// plus a count of the cycles the run took. Both results come with level
// valid flags that stay high until uut_ctrl is raised again.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   uut_ctrl     synchronous hold; high forces HOLD and clears the outputs
//   din          stimulus, byte k = din[8k+7:8k], byte 0 processed first
//   crc_out      final CRC (result 1)
//   crc_valid    level flag, crc_out valid
//   cycles_out   run length in cycles (result 2)
//   cycles_valid level flag, cycles_out valid
module autotest_crc32_uut #(
   parameter int          DATA_BYTES = 16,
   parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
   parameter logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    uut_ctrl,
   input  logic [8*DATA_BYTES-1:0] din,
   output logic [31:0]             crc_out,
   output logic                    crc_valid,
   output logic [31:0]             cycles_out,
   output logic                    cycles_valid
);

   localparam int NB = 8 * DATA_BYTES;
   localparam int CW = $clog2(NB + 1);
   localparam logic [31:0] POLY = 32'hEDB8_8320;

   typedef enum logic [2:0] {HOLD, LOAD, SHIFT, FINAL, DONE} state_t;

   state_t          state, state_nxt;
   logic [NB-1:0]   sreg;
   logic [31:0]     crc;
   logic [CW-1:0]   bit_cnt;
   logic [31:0]     cyc_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= HOLD;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (uut_ctrl) begin
         state_nxt = HOLD;
      end else begin
         case (state)
            HOLD:  state_nxt = LOAD;
            LOAD:  state_nxt = SHIFT;
            SHIFT: if (bit_cnt == CW'(NB - 1)) state_nxt = FINAL;
            FINAL: state_nxt = DONE;
            DONE:  state_nxt = DONE;
            default: state_nxt = HOLD;
         endcase
      end
   end

   // din is captured on the edge that leaves HOLD (E0), so any later change
   // to the stimulus cannot reach the running computation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg       <= '0;
         crc        <= '0;
         bit_cnt    <= '0;
         cyc_cnt    <= '0;
         crc_out    <= '0;
         cycles_out <= '0;
      end else if (uut_ctrl) begin
         sreg       <= '0;
         crc        <= '0;
         bit_cnt    <= '0;
         cyc_cnt    <= '0;
         crc_out    <= '0;
         cycles_out <= '0;
      end else begin
         case (state)
            HOLD: begin
               sreg       <= din;
               crc        <= '0;
               bit_cnt    <= '0;
               cyc_cnt    <= '0;
               crc_out    <= '0;
               cycles_out <= '0;
            end
            LOAD: begin
               crc     <= CRC_INIT;
               bit_cnt <= '0;
               cyc_cnt <= 32'd1;
            end
            SHIFT: begin
               sreg    <= sreg >> 1;
               crc     <= (crc >> 1) ^ ({32{crc[0] ^ sreg[0]}} & POLY);
               bit_cnt <= bit_cnt + CW'(1);
               cyc_cnt <= cyc_cnt + 32'd1;
            end
            FINAL: begin
               crc_out    <= crc ^ CRC_XOROUT;
               cycles_out <= cyc_cnt + 32'd1;
            end
            default: ;
         endcase
      end
   end

   // Flags decode the registered state, so they stay level for the whole of
   // DONE and drop on the same edge that clears the results.
   assign crc_valid    = (state == DONE);
   assign cycles_valid = (state == DONE);

endmodule

// File: tb/tb_autotest_crc32_uut.sv
module tb_autotest_crc32_uut;

   logic clk = 1'b0;
   logic rst;
   logic         uc   [3];
   logic [127:0] dinv [3];
   logic [31:0]  crc_o [3];
   logic [31:0]  cyc_o [3];
   logic         cv   [3];
   logic         yv   [3];
   logic [7:0]   din1;
   logic [71:0]  din9;
   logic [127:0] din16;

   int n_cmp = 0;
   int n_bad = 0;
   int nb [3] = '{1, 9, 16};

   always #5 clk = ~clk;

   assign din1  = dinv[0][7:0];
   assign din9  = dinv[1][71:0];
   assign din16 = dinv[2];

   autotest_crc32_uut #(.DATA_BYTES(1)) u_n1 (
      .clk(clk), .rst(rst), .uut_ctrl(uc[0]), .din(din1),
      .crc_out(crc_o[0]), .crc_valid(cv[0]), .cycles_out(cyc_o[0]), .cycles_valid(yv[0]));
   autotest_crc32_uut #(.DATA_BYTES(9)) u_n9 (
      .clk(clk), .rst(rst), .uut_ctrl(uc[1]), .din(din9),
      .crc_out(crc_o[1]), .crc_valid(cv[1]), .cycles_out(cyc_o[1]), .cycles_valid(yv[1]));
   autotest_crc32_uut #(.DATA_BYTES(16)) u_n16 (
      .clk(clk), .rst(rst), .uut_ctrl(uc[2]), .din(din16),
      .crc_out(crc_o[2]), .crc_valid(cv[2]), .cycles_out(cyc_o[2]), .cycles_valid(yv[2]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Textbook byte-wise software CRC-32 (reflected, poly EDB88320).
   function automatic logic [31:0] crc_ref(input logic [127:0] d, input int n);
      logic [31:0] c = 32'hFFFF_FFFF;
      for (int k = 0; k < n; k++) begin
         c = c ^ {24'h0, d[8*k +: 8]};
         for (int b = 0; b < 8; b++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic start(input int i);
      @(negedge clk);
      uc[i] = 1'b0;
   endtask

   // Called with the run's E0 edge still ahead; 'already' negedges consumed.
   task automatic finish(input int i, input logic [31:0] exp, input string tag, input int already);
      int n = nb[i];
      repeat (8*n + 2 - already) @(negedge clk);
      chk({tag, " valid_early"}, {63'h0, cv[i] | yv[i]}, 64'h0);
      @(negedge clk);
      chk({tag, " crc_valid"}, {63'h0, cv[i]}, 64'h1);
      chk({tag, " cycles_valid"}, {63'h0, yv[i]}, 64'h1);
      chk({tag, " crc"}, {32'h0, crc_o[i]}, {32'h0, exp});
      chk({tag, " cycles"}, {32'h0, cyc_o[i]}, 64'(8*n + 2));
      repeat (3) @(negedge clk);
      chk({tag, " held"}, {30'h0, cv[i], yv[i], crc_o[i]}, {30'h0, 2'b11, exp});
   endtask

   // One-edge uut_ctrl pulse; optionally releases on the check edge so the
   // next run's E0 is the very next posedge.
   task automatic stop(input int i, input string tag, input bit relaunch);
      @(negedge clk);
      uc[i] = 1'b1;
      @(negedge clk);
      chk({tag, " cleared"}, {cv[i], yv[i], crc_o[i], cyc_o[i][29:0]}, 64'h0);
      if (relaunch) uc[i] = 1'b0;
   endtask

   initial begin
      logic [127:0] orig;
      logic [31:0]  first_crc, first_cyc;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         uc[i] = 1'b1;
         dinv[i] = '0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++)
         chk($sformatf("reset_state[%0d]", i),
             {cv[i], yv[i], crc_o[i], cyc_o[i][29:0]}, 64'h0);
      rst = 1'b0;

      // Single zero byte.
      dinv[0] = '0;
      start(0);
      finish(0, 32'hD202_EF8D, "single_byte", 0);
      stop(0, "single_byte", 1'b0);

      // Standard check value "123456789".
      for (int k = 0; k < 9; k++) dinv[1][8*k +: 8] = 8'h31 + 8'(k);
      start(1);
      finish(1, 32'hCBF4_3926, "check_value", 0);

      // Async reset in DONE, between edges; the run restarts on release.
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("async_reset", {cv[1], yv[1], crc_o[1], cyc_o[1][29:0]}, 64'h0);
      #1 rst = 1'b0;
      finish(1, 32'hCBF4_3926, "after_reset", 0);
      stop(1, "after_reset", 1'b0);

      // Stimulus change after start.
      orig = {$urandom, $urandom, $urandom, $urandom};
      dinv[2] = orig;
      start(2);
      repeat (5) @(negedge clk);
      dinv[2] = '1;
      finish(2, crc_ref(orig, 16), "din_change", 5);
      stop(2, "din_change", 1'b0);

      // Hold raised while bit 37 is being shifted.
      dinv[2] = {$urandom, $urandom, $urandom, $urandom};
      start(2);
      repeat (39) @(negedge clk);
      uc[2] = 1'b1;
      @(negedge clk);
      chk("hold_mid_run", {cv[2], yv[2], crc_o[2], cyc_o[2][29:0]}, 64'h0);
      start(2);
      finish(2, crc_ref(dinv[2], 16), "after_hold", 0);
      stop(2, "after_hold", 1'b0);

      // Repeatability with a one-edge pulse between runs.
      dinv[0] = {120'h0, 8'($urandom)};
      start(0);
      finish(0, crc_ref(dinv[0], 1), "repeat_a", 0);
      first_crc = crc_o[0];
      first_cyc = cyc_o[0];
      stop(0, "repeat_gap", 1'b1);
      finish(0, crc_ref(dinv[0], 1), "repeat_b", 0);
      chk("repeat_same", {crc_o[0], cyc_o[0]}, {first_crc, first_cyc});
      stop(0, "repeat_b", 1'b0);

      // Randomized runs on every instance.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 3; i++) begin
            dinv[i] = {$urandom, $urandom, $urandom, $urandom};
            start(i);
            finish(i, crc_ref(dinv[i], nb[i]), $sformatf("rand%0d_n%0d", r, nb[i]), 0);
            stop(i, $sformatf("rand%0d_n%0d", r, nb[i]), 1'b0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
